// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder.
// The optional FEEDER_PERF_CNT_EN feature is handled in the top module.
package feeder_pkg;

  // Feeder control states; the encoding is visible on the dbg_state port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_e;

  // Ceiling log2, never below 1, used to size the small counters.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_line.sv
// Fixed-depth delay line with asynchronous active-low reset to zero.
// DEPTH=0 degenerates to a plain wire.
module skew_line
  import feeder_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_reg
    logic [WIDTH-1:0] sr [DEPTH];

    // Shift the word one stage per clock; reset empties the line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
      end else begin
        sr[0] <= d;
        for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for one edge of a systolic PE array.
// Accepts one LANES-wide vector per cycle, tags the first beat of every
// K_LEN-beat accumulation block with finish, delays lane i by i cycles and
// closes each stream with a zero flush beat carrying finish on all lanes.
// Optional build macro: FEEDER_PERF_CNT_EN adds perf_beats / perf_bubbles.
module systolic_skew_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int K_LEN      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_finish,
  output logic                        busy,
  output logic                        done,
`ifdef FEEDER_PERF_CNT_EN
  output logic [CNT_W-1:0]            perf_beats,
  output logic [CNT_W-1:0]            perf_bubbles,
`endif
  output logic [1:0]                  dbg_state
);

  localparam int KW  = clog2(K_LEN);
  localparam int DCW = clog2(LANES);
  localparam int LW  = LANES * DATA_WIDTH;

  feeder_state_e  state;
  logic [KW-1:0]  k_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [LW-1:0]  s0_data;
  logic           s0_fin;
  logic           accept;

  // Handshake: a beat transfers on a rising clk edge where in_valid and
  // in_ready are both high. in_ready depends only on the registered state
  // (high in IDLE and STREAM), never on in_valid; upstream may hold
  // in_valid/in_data/in_last across not-ready cycles.
  assign in_ready  = (state == IDLE) || (state == STREAM);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Control FSM: stream until in_last, one flush cycle, then drain the skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= in_last ? FLUSH : STREAM;
        end
        STREAM: begin
          if (accept && in_last) state <= FLUSH;
        end
        FLUSH: begin
          if (LANES == 1) begin
            state <= IDLE;
          end else begin
            state     <= DRAIN;
            drain_cnt <= DCW'(LANES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt <= DCW'(1)) state <= IDLE;
          drain_cnt <= drain_cnt - DCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Block position counter; only accepted beats move it, in_last rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt <= '0;
    end else if (accept) begin
      if (in_last || (k_cnt == KW'(K_LEN - 1))) k_cnt <= '0;
      else k_cnt <= k_cnt + KW'(1);
    end
  end

  // Stage 0: accepted vector, flush beat, or a zero bubble (array never stalls).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_data <= '0;
      s0_fin  <= 1'b0;
    end else if (accept) begin
      s0_data <= in_data;
      s0_fin  <= (k_cnt == '0);
    end else if (state == FLUSH) begin
      s0_data <= '0;
      s0_fin  <= 1'b1;
    end else begin
      s0_data <= '0;
      s0_fin  <= 1'b0;
    end
  end

  // done marks the cycle the flush beat appears on the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else done <= ((state == DRAIN) && (drain_cnt == DCW'(1))) ||
                 ((LANES == 1) && (state == FLUSH));
  end

  // Diagonal skew: lane i sees stage 0 delayed by i more cycles, finish alongside.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH:0] lane_q;

    skew_line #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (i)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({s0_fin, s0_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .q     (lane_q)
    );

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[DATA_WIDTH-1:0];
    assign out_finish[i]                        = lane_q[DATA_WIDTH];
  end

`ifdef FEEDER_PERF_CNT_EN
  // Saturating stream statistics, restarted whenever a new stream begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats   <= '0;
      perf_bubbles <= '0;
    end else if ((state == IDLE) && accept) begin
      perf_beats   <= CNT_W'(1);
      perf_bubbles <= '0;
    end else begin
      if (accept && (perf_beats != '1)) perf_beats <= perf_beats + CNT_W'(1);
      if ((state == STREAM) && !accept && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (LANES=4, K_LEN=4).
// Reference model: per-cycle stage-0 history derived from the stream rules,
// lane i expected = history entry i cycles old.
module tb_systolic_skew_feeder;

  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int K_LEN = 4;
  localparam int CNT_W = 16;
  localparam int LW    = LANES * DW;

  typedef struct {
    logic [LW-1:0] data;
    logic          fin;
    logic          flush;
  } entry_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [LW-1:0] out_data;
  logic [LANES-1:0] out_finish;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;
`ifdef FEEDER_PERF_CNT_EN
  logic [CNT_W-1:0] perf_beats;
  logic [CNT_W-1:0] perf_bubbles;
`endif

  systolic_skew_feeder #(
    .DATA_WIDTH (DW),
    .LANES      (LANES),
    .K_LEN      (K_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_data   (out_data),
    .out_finish (out_finish),
    .busy       (busy),
    .done       (done),
`ifdef FEEDER_PERF_CNT_EN
    .perf_beats   (perf_beats),
    .perf_bubbles (perf_bubbles),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  entry_t hist[$];          // hist[0] = newest stage-0 content
  int     m_nrl;            // cycles left with in_ready low
  int     m_beat;           // accepted beats so far in current block
  bit     m_flush_next;
  bit     m_streaming;
  logic [CNT_W-1:0] m_beats, m_bubbles;

  int obs_not_ready;
  int obs_done;
  int obs_fin_last;

  task automatic model_clear();
    hist.delete();
    m_nrl = 0;
    m_beat = 0;
    m_flush_next = 0;
    m_streaming = 0;
    m_beats = '0;
    m_bubbles = '0;
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive at negedge, predict, then compare after the edge.
  task automatic step(input logic v, input logic [LW-1:0] d, input logic l, output bit acc_o);
    entry_t e;
    entry_t h;
    bit exp_rdy, acc, fl_now;
    logic [LW-1:0] exp_data;
    logic [LANES-1:0] exp_fin;
    logic exp_done, exp_busy;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    #1;
    exp_rdy = (m_nrl == 0);
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    if (in_ready === 1'b0) obs_not_ready++;
    acc = v && exp_rdy;
    fl_now = m_flush_next;
    m_flush_next = 0;
    if (m_nrl > 0) m_nrl--;
    if (m_streaming && !acc && m_bubbles != '1) m_bubbles++;
    e.data = '0;
    e.fin = 1'b0;
    e.flush = 1'b0;
    if (acc) begin
      e.data = d;
      e.fin = (m_beat == 0);
      if (!m_streaming) begin
        m_beats = 1;
        m_bubbles = '0;
      end else if (m_beats != '1) begin
        m_beats++;
      end
      if (l) begin
        m_beat = 0;
        m_nrl = LANES;
        m_flush_next = 1;
        m_streaming = 0;
      end else begin
        m_beat = (m_beat + 1) % K_LEN;
        m_streaming = 1;
      end
    end else if (fl_now) begin
      e.fin = 1'b1;
      e.flush = 1'b1;
    end
    hist.push_front(e);
    if (hist.size() > LANES) void'(hist.pop_back());

    exp_data = '0;
    exp_fin = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < hist.size()) begin
        h = hist[i];
        exp_data[i*DW +: DW] = h.data[i*DW +: DW];
        exp_fin[i] = h.fin;
      end
    end
    exp_done = 1'b0;
    if (hist.size() == LANES) begin
      h = hist[LANES-1];
      exp_done = h.flush;
    end
    exp_busy = m_streaming || (m_nrl > 0);
    acc_o = acc;

    @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== exp_data) begin
      n_fail++;
      $display("FAIL out_data: got %h expected %h at %0t", out_data, exp_data, $time);
    end
    n_checks++;
    if (out_finish !== exp_fin) begin
      n_fail++;
      $display("FAIL out_finish: got %b expected %b at %0t", out_finish, exp_fin, $time);
    end
    n_checks++;
    if (done !== exp_done) begin
      n_fail++;
      $display("FAIL done: got %b expected %b at %0t", done, exp_done, $time);
    end
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy: got %b expected %b at %0t", busy, exp_busy, $time);
    end
`ifdef FEEDER_PERF_CNT_EN
    n_checks++;
    if (perf_beats !== m_beats || perf_bubbles !== m_bubbles) begin
      n_fail++;
      $display("FAIL perf: got %0d/%0d expected %0d/%0d at %0t",
               perf_beats, perf_bubbles, m_beats, m_bubbles, $time);
    end
`endif
    if (done === 1'b1) obs_done++;
    if (out_finish[LANES-1] === 1'b1) obs_fin_last++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
  endtask

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom_range(1, 255));
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_data !== '0 || out_finish !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h fin=%b done=%b busy=%b expected all zero",
               out_data, out_finish, done, busy);
    end
    n_checks++;
    if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b state=%0d expected 1/0", in_ready, dbg_state);
    end
`ifdef FEEDER_PERF_CNT_EN
    n_checks++;
    if (perf_beats !== '0 || perf_bubbles !== '0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_beats, perf_bubbles);
    end
`endif
  endtask

  task automatic test_skew();
    bit a;
    do_reset();
    step(1'b1, 32'h04030201, 1'b0, a);
    n_checks++;
    if (out_data[7:0] !== 8'd1 || out_finish[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_lane0_c1: got %0d fin=%b expected 1 fin=1", out_data[7:0], out_finish[0]);
    end
    step(1'b1, 32'h08070605, 1'b1, a);
    n_checks++;
    if (out_data[7:0] !== 8'd5 || out_finish[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_lane0_c2: got %0d fin=%b expected 5 fin=0", out_data[7:0], out_finish[0]);
    end
    idle(2);
    n_checks++;
    if (out_data[31:24] !== 8'd4 || out_finish[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_lane3_c4: got %0d fin=%b expected 4 fin=1", out_data[31:24], out_finish[3]);
    end
    idle(1);
    n_checks++;
    if (out_data[31:24] !== 8'd8 || out_finish[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_lane3_c5: got %0d fin=%b expected 8 fin=0", out_data[31:24], out_finish[3]);
    end
    idle(3);
  endtask

  task automatic test_blocks();
    bit a;
    do_reset();
    obs_fin_last = 0;
    obs_done = 0;
    for (int b = 0; b < 9; b++) step(1'b1, rand_vec(), (b == 8), a);
    idle(LANES + 1);
    n_checks++;
    if (obs_fin_last != 4 || obs_done != 1) begin
      n_fail++;
      $display("FAIL blocks_finish_count: got fin=%0d done=%0d expected 4/1", obs_fin_last, obs_done);
    end
  endtask

  task automatic test_bubbles();
    bit a;
    do_reset();
    step(1'b1, rand_vec(), 1'b0, a);
    step(1'b0, rand_vec(), 1'b0, a);
    n_checks++;
    if (out_data[7:0] !== 8'd0 || out_finish[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_zero: got %0d fin=%b expected 0 fin=0", out_data[7:0], out_finish[0]);
    end
    step(1'b1, rand_vec(), 1'b1, a);
`ifdef FEEDER_PERF_CNT_EN
    n_checks++;
    if (perf_beats !== 16'd2 || perf_bubbles !== 16'd1) begin
      n_fail++;
      $display("FAIL perf_bubble_scenario: got %0d/%0d expected 2/1", perf_beats, perf_bubbles);
    end
`endif
    idle(LANES + 1);
    // Longer run: finish must land on the 5th accepted beat, not the 4th.
    for (int b = 0; b < 6; b++) step(b != 2, rand_vec(), (b == 5), a);
    idle(LANES + 1);
  endtask

  task automatic test_single();
    bit a;
    do_reset();
    obs_not_ready = 0;
    obs_done = 0;
    step(1'b1, rand_vec(), 1'b1, a);
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL single_flush_state: got %0d expected 2", dbg_state);
    end
    idle(LANES);
    n_checks++;
    if (done !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done_ready: got done=%b ready=%b expected 1/1", done, in_ready);
    end
    idle(3);
    n_checks++;
    if (obs_not_ready != 4 || obs_done != 1) begin
      n_fail++;
      $display("FAIL single_counts: got not_ready=%0d done=%0d expected 4/1", obs_not_ready, obs_done);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int got;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      got = 0;
      while (got < 3) begin
        step(1'b1, rand_vec(), (got == 2), a);
        if (a) got++;
      end
    end
    idle(LANES + 2);
  endtask

  task automatic test_random();
    bit a;
    int len, got, guard;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      len = $urandom_range(1, 12);
      got = 0;
      guard = 0;
      while (got < len && guard < 200) begin
        step($urandom_range(0, 3) != 0, rand_vec(), (got == len - 1), a);
        if (a) got++;
        guard++;
      end
      n_checks++;
      if (got != len) begin
        n_fail++;
        $display("FAIL random_stream_timeout: got %0d beats expected %0d", got, len);
      end
      idle($urandom_range(0, LANES + 2));
    end
    idle(LANES + 2);
  endtask

  task automatic test_reset_mid_drain();
    bit a;
    do_reset();
    step(1'b1, rand_vec(), 1'b0, a);
    step(1'b1, rand_vec(), 1'b1, a);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_data !== '0 || out_finish !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got data=%h fin=%b expected 0/0", out_data, out_finish);
    end
    n_checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_state: got state=%0d busy=%b ready=%b expected 0/0/1",
               dbg_state, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    idle(2);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_clear();
    test_reset();
    test_skew();
    test_blocks();
    test_bubbles();
    test_single();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
